// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the systolic GEMM engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tpu_pkg;

  // Sequencer states of the GEMM controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Counter widths for the default 2x2, K_MAX=16 configuration.
  localparam int DEF_K_MAX   = 16;
  localparam int DEF_KLEN_W  = $clog2(DEF_K_MAX + 1);
  localparam int DEF_FLUSH_W = $clog2(2 + 2 + 1);
  localparam int DEF_ROW_W   = 1;

  // Accumulator wide enough for K_MAX full-width products.
  function automatic int acc_w_default(input int d_w, input int k_max);
    return 2 * d_w + $clog2(k_max);
  endfunction

  // Width of the job-depth field and beat counter.
  function automatic int klen_w(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Width of the flush-phase counter.
  function automatic int flush_w(input int rows, input int cols);
    return $clog2(rows + cols + 1);
  endfunction

  // Width of the drain row index (at least one bit).
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/pe_acc.sv
// Single output-stationary PE: forwards x right and y down, accumulates x*y.
// Latency: pass-through registers and accumulator update one cycle after en.
// Backpressure: none; holds all state while en is low.
// Ports: clk/rst; en advances the PE; clr zeroes all state; x_in/y_in operands;
//        x_out/y_out registered pass-through; acc running sum.
module pe_acc #(
  parameter int D_W    = 8,
  parameter int ACC_W  = 20,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [D_W-1:0]   x_in,
  input  logic [D_W-1:0]   y_in,
  output logic [D_W-1:0]   x_out,
  output logic [D_W-1:0]   y_out,
  output logic [ACC_W-1:0] acc
);

  localparam int P_W = 2 * D_W;

  logic [P_W-1:0]   x_ext;
  logic [P_W-1:0]   y_ext;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] prod_ext;

  // The low 2*D_W bits of the product of sign-extended operands equal the
  // two's-complement product, so one multiplier serves both modes.
  always_comb begin
    x_ext    = {{D_W{SIGNED & x_in[D_W-1]}}, x_in};
    y_ext    = {{D_W{SIGNED & y_in[D_W-1]}}, y_in};
    prod     = x_ext * y_ext;
    prod_ext = {{(ACC_W-P_W){SIGNED & prod[P_W-1]}}, prod};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_out <= '0;
      y_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      x_out <= '0;
      y_out <= '0;
      acc   <= '0;
    end else if (en) begin
      x_out <= x_in;
      y_out <= y_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_gemm.sv
// Output-stationary ROWSxCOLS systolic GEMM with sequencer, skew lines and row drain.
// Latency: first result row ROWS+COLS cycles after the final accepted beat; k_len=0 drains next cycle.
// Backpressure: operand side stalls the whole array via in_valid; drain holds row/data while out_ready is low.
// Ports: clk/rst; start+k_len job request; busy; in_valid/in_ready with x_flat/y_flat operand beats;
//        out_valid/out_ready with out_row/out_data result rows; done pulse after the final row.
module systolic_gemm
  import tpu_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int K_MAX  = 16,
  parameter int ACC_W  = acc_w_default(D_W, K_MAX),
  parameter bit SIGNED = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         busy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*D_W-1:0]          x_flat,
  input  logic [COLS*D_W-1:0]          y_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [row_w(ROWS)-1:0]       out_row,
  output logic [COLS*ACC_W-1:0]        out_data,
  output logic                         done
);

  localparam int KW = klen_w(K_MAX);
  localparam int FW = flush_w(ROWS, COLS);
  localparam int RW = row_w(ROWS);
  localparam logic [KW-1:0] K_MAX_V    = KW'(K_MAX);
  // Last useful product reaches PE(ROWS-1,COLS-1) ROWS+COLS-2 advances after the last beat.
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_t          state, state_nxt;
  logic [KW-1:0]   k_q, k_eff, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            accept, adv, clr, last_beat, flush_end, out_fire, last_row;

  assign k_eff     = (k_len > K_MAX_V) ? K_MAX_V : k_len;
  assign accept    = in_valid && in_ready;
  assign clr       = (state == IDLE) && start;
  // Array moves only on accepted beats or during flush; otherwise it holds.
  assign adv       = accept || (state == FLUSH);
  assign last_beat = accept && (beat_cnt == k_q - 1'b1);
  assign flush_end = (state == FLUSH) && (flush_cnt == FLUSH_LAST);
  assign out_fire  = out_valid && out_ready;
  assign last_row  = out_fire && (out_row == ROW_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_eff == '0) ? DRAIN : LOAD;
      LOAD:    if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = DRAIN;
      DRAIN:   if (last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = (state != IDLE);
    in_ready = (state == LOAD);
  end

  // ---------------- counters and done ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q       <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= last_row;
      if (clr) begin
        k_q      <= k_eff;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;
    end
  end

  // ---------------- skew lines and PE grid ----------------
  logic [D_W-1:0]   x_edge [ROWS];
  logic [D_W-1:0]   y_edge [COLS];
  logic [D_W-1:0]   x_pass [ROWS][COLS];
  logic [D_W-1:0]   y_pass [ROWS][COLS];
  logic [ACC_W-1:0] acc_grid [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_xskew
    logic [D_W-1:0] x_src;
    // Zeros are fed at the edge outside LOAD so flushing adds nothing.
    assign x_src = (state == LOAD) ? x_flat[r*D_W +: D_W] : '0;
    if (r == 0) begin : g_d0
      assign x_edge[r] = x_src;
    end else begin : g_dl
      logic [D_W-1:0] dl [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int i = 0; i < r; i++) dl[i] <= '0;
        end else if (adv) begin
          dl[0] <= x_src;
          for (int i = 1; i < r; i++) dl[i] <= dl[i-1];
        end
      end
      assign x_edge[r] = dl[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_yskew
    logic [D_W-1:0] y_src;
    assign y_src = (state == LOAD) ? y_flat[c*D_W +: D_W] : '0;
    if (c == 0) begin : g_d0
      assign y_edge[c] = y_src;
    end else begin : g_dl
      logic [D_W-1:0] dl [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int i = 0; i < c; i++) dl[i] <= '0;
        end else if (adv) begin
          dl[0] <= y_src;
          for (int i = 1; i < c; i++) dl[i] <= dl[i-1];
        end
      end
      assign y_edge[c] = dl[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [D_W-1:0] x_in_w, y_in_w;
      if (c == 0) begin : g_xl
        assign x_in_w = x_edge[r];
      end else begin : g_xi
        assign x_in_w = x_pass[r][c-1];
      end
      if (r == 0) begin : g_yt
        assign y_in_w = y_edge[c];
      end else begin : g_yi
        assign y_in_w = y_pass[r-1][c];
      end
      pe_acc #(.D_W(D_W), .ACC_W(ACC_W), .SIGNED(SIGNED)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .clr   (clr),
        .x_in  (x_in_w),
        .y_in  (y_in_w),
        .x_out (x_pass[r][c]),
        .y_out (y_pass[r][c]),
        .acc   (acc_grid[r][c])
      );
    end
  end

  // ---------------- drain row multiplexer ----------------
  logic [RW-1:0]          sel_row;
  logic [COLS*ACC_W-1:0]  sel_data;

  // Row 0 is loaded on DRAIN entry; afterwards the following row is preloaded on each handshake.
  always_comb begin
    sel_row  = out_valid ? out_row + 1'b1 : '0;
    sel_data = '0;
    for (int c = 0; c < COLS; c++) sel_data[c*ACC_W +: ACC_W] = acc_grid[sel_row][c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
    end else if (clr) begin
      // A zero-depth job presents all-zero rows immediately.
      out_valid <= (k_eff == '0);
      out_row   <= '0;
      out_data  <= '0;
    end else if (state == DRAIN) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_row   <= '0;
        out_data  <= sel_data;
      end else if (out_ready) begin
        if (last_row) begin
          out_valid <= 1'b0;
        end else begin
          out_row  <= out_row + 1'b1;
          out_data <= sel_data;
        end
      end
    end
  end

endmodule

// File: doc/systolic_gemm.md
# systolic_gemm

Output-stationary ROWS×COLS systolic matrix-multiply engine with an integrated sequencing controller. Accepts K streamed beats of an X column-vector and a Y row-vector through a valid/ready handshake, skews them internally, and accumulates C = Σₖ xₖ·yₖᵀ in place. It then drains results one row per beat over a second valid/ready stream. It sits between the operand feeders and the result writeback, replacing the bare init-chained MAC grid with a self-timed, back-pressurable, variable-depth core.

## Interface
- D_W, 8: operand width.
- ROWS, 2: PE rows; X vector length.
- COLS, 2: PE columns; Y vector length.
- K_MAX, 16: maximum accumulation depth per job.
- ACC_W, 2*D_W+$clog2(K_MAX): accumulator and result width.
- SIGNED, 0: 1 selects two's-complement operands and products; 0 selects unsigned.

- clk  in  1  sole clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle job request; sampled in IDLE only.
- k_len  in  $clog2(K_MAX+1)  job depth; captured with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- x_flat  in  ROWS*D_W  row r at [r*D_W +: D_W].
- y_flat  in  COLS*D_W  column c at [c*D_W +: D_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  result sink ready.
- out_row  out  $clog2(ROWS) (min 1)  index of the presented row.
- out_data  out  COLS*ACC_W  C[out_row][c] at [c*ACC_W +: ACC_W].
- done  out  1  one-cycle pulse on the cycle after the final output handshake.

## Operation
- States are IDLE, LOAD, FLUSH and DRAIN.
- **IDLE**
  - start captures k_len and clears all accumulators and skew registers.
  - If k_len==0 → DRAIN, producing all-zero results. Otherwise → LOAD.
- **LOAD**
  - A beat is accepted when in_valid && in_ready.
  - Accepted x[r] enters a delay line of depth r; y[c] enters a delay line of depth c.
  - The array and skew lines advance only on accepted beats. Without an accepted beat the array holds completely (clock-enable), so in_valid gaps never corrupt alignment.
  - After the k_len-th accepted beat → FLUSH.
- **FLUSH**
  - Lasts exactly ROWS+COLS-1 cycles, with a counter.
  - Zeros are injected at the array edges and the array advances every cycle.
  - → DRAIN.
- **DRAIN**
  - Rows are presented in order 0..ROWS-1.
  - The row index advances on out_valid && out_ready.
  - After the handshake on row ROWS-1 → IDLE, with done pulsed on the following cycle.
- **PE behaviour:** each PE registers the x it passes right and the y it passes down. When enabled it performs acc ← acc + x·y.
  - The product is the full 2*D_W width; it is sign- or zero-extended to ACC_W per SIGNED.
  - The sum wraps modulo 2^ACC_W with no saturation.
- start in any non-IDLE state is ignored.
- k_len > K_MAX is clamped to K_MAX.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, out_row=0, out_data=0, done=0, state=IDLE, all accumulators 0.
- Reset mid-job aborts immediately with no partial output.
- in_ready rises the cycle after start is sampled with k_len≠0.
- in_ready falls on the edge that accepts beat k_len.
- out_valid is asserted exactly ROWS+COLS cycles after the edge accepting the final beat.
  - For k_len==0, out_valid is asserted the cycle after start.
- out_data and out_row are held stable while out_valid && !out_ready.
- With out_ready held high, one row is produced per cycle. Total job latency is k_len + (ROWS+COLS) + ROWS cycles, plus any stalls.
- done is coincident with busy falling. The next start is accepted on the same cycle done is high.

## Structure
- Shared package tpu_pkg holds:
  - the state enum: IDLE, LOAD, FLUSH, DRAIN
  - a function for the default ACC_W
  - localparams for the counter widths.
- One sub-module, pe_acc, implements a single PE with enable, clear, pass-through registers and a SIGNED-aware multiply-accumulate.
- The top level contains the FSM, the skew delay lines, the generate-built pe_acc grid and the drain row multiplexer.

## Test plan
- ROWS=COLS=2, k_len=1, x=(3,5), y=(7,2) → rows (21,6), (35,10); done after the row-1 handshake.
- k_len=4 with 2-cycle in_valid gaps between beats → results identical to the gap-free run; in_ready is never high in FLUSH.
- out_ready toggled 1-in-3 during DRAIN → out_data/out_row stable during stalls; exactly ROWS handshakes occur.
- k_len=0 → all-zero rows; out_valid is asserted the cycle after start.
- SIGNED=1, D_W=8, k_len=16, x=y=-128 at every beat → each entry 262144 truncated to ACC_W=20, giving 0x40000. Then SIGNED=1 with x=-1, y=3 → each entry -48.
- rst asserted mid-LOAD, then a new job → outputs reset asynchronously; the new job matches its golden model with no residue from the aborted job.
